// File: rtl/insn_pkg.sv
// Shared RV32I instruction field definitions for the encode and decode stages.
package insn_pkg;

   localparam int XLEN  = 32;
   localparam int OPC_W = 7;
   localparam int F3_W  = 3;
   localparam int F7_W  = 7;
   localparam int REG_W = 5;
   localparam int FMT_W = 3;

   // Instruction formats; encodings 6 and 7 are deliberately left unnamed (illegal).
   typedef enum logic [FMT_W-1:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   // ADDI x0,x0,0 -- substituted for any instruction that cannot be encoded.
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/insn_pack.sv
// Combinational RV32I packer: instruction fields -> 32-bit word plus an illegal flag.
// An illegal format or out-of-range immediate yields the NOP word.
module insn_pack
   import insn_pkg::*;
(
   input  logic [FMT_W-1:0] fmt_i,
   input  logic [OPC_W-1:0] opcode_i,
   input  logic [F3_W-1:0]  funct3_i,
   input  logic [F7_W-1:0]  funct7_i,
   input  logic [REG_W-1:0] rd_i,
   input  logic [REG_W-1:0] rs1_i,
   input  logic [REG_W-1:0] rs2_i,
   input  logic [XLEN-1:0]  imm_i,
   output logic [XLEN-1:0]  word_o,
   output logic             illegal_o
);

   logic signed [XLEN-1:0] imm_s;
   logic [XLEN-1:0]        raw_word;
   logic                   imm_ok;

   assign imm_s = $signed(imm_i);

   // Place the fields per format and range-check the immediate it can carry.
   always_comb begin
      raw_word = '0;
      imm_ok   = 1'b1;
      case (fmt_i)
         FMT_R: begin
            raw_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         end
         FMT_I: begin
            imm_ok   = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            raw_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
         end
         FMT_S: begin
            imm_ok   = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            raw_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
         end
         FMT_B: begin
            imm_ok   = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm_i[0];
            raw_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                        imm_i[4:1], imm_i[11], opcode_i};
         end
         FMT_U: begin
            imm_ok   = (imm_i[11:0] == 12'd0);
            raw_word = {imm_i[31:12], rd_i, opcode_i};
         end
         FMT_J: begin
            imm_ok   = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm_i[0];
            raw_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
         end
         default: begin
            imm_ok = 1'b0;
         end
      endcase
   end

   assign illegal_o = !imm_ok;
   assign word_o    = imm_ok ? raw_word : NOP;

endmodule

// File: rtl/insn_encoder.sv
// Instruction encoder/loader: accepts fields over valid/ready, packs them and
// writes the words to consecutive imem addresses through a 2-entry FIFO.
module insn_encoder
   import insn_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int CNT_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]  num_insns,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [FMT_W-1:0]      fmt,
   input  logic [OPC_W-1:0]      opcode,
   input  logic [F3_W-1:0]       funct3,
   input  logic [F7_W-1:0]       funct7,
   input  logic [REG_W-1:0]      rd,
   input  logic [REG_W-1:0]      rs1,
   input  logic [REG_W-1:0]      rs2,
   input  logic [XLEN-1:0]       imm,
   output logic                  imem_we,
   input  logic                  imem_ready,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [XLEN-1:0]       imem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [CNT_WIDTH-1:0]  err_index
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

   state_e                state_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  err_q;
   logic [CNT_WIDTH-1:0]  err_idx_q;
   logic [CNT_WIDTH-1:0]  acc_q;
   logic [CNT_WIDTH-1:0]  num_q;

   logic [XLEN-1:0]       mem_q [2];
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [1:0]            count_q;
   logic [1:0]            count_d;
   logic [ADDR_WIDTH-1:0] addr_q;

   logic [XLEN-1:0]       pack_word;
   logic                  pack_illegal;
   logic                  start_take;
   logic                  push;
   logic                  pop;
   logic                  last_accept;

   insn_pack u_pack (
      .fmt_i     (fmt),
      .opcode_i  (opcode),
      .funct3_i  (funct3),
      .funct7_i  (funct7),
      .rd_i      (rd),
      .rs1_i     (rs1),
      .rs2_i     (rs2),
      .imm_i     (imm),
      .word_o    (pack_word),
      .illegal_o (pack_illegal)
   );

   // A full FIFO refuses input even if it pops this cycle (no pass-through).
   assign in_ready    = (state_q == S_LOAD) && (count_q != 2'd2);
   assign start_take  = (state_q == S_IDLE) && start;
   assign push        = in_valid && in_ready;
   assign pop         = (count_q != 2'd0) && imem_ready;
   assign last_accept = (acc_q == num_q - CNT_WIDTH'(1));

   // Occupancy after this cycle's push/pop; also tells DRAIN the FIFO empties now.
   always_comb begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   // Control FSM with accept counter, sticky error capture and registered status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_idx_q <= '0;
         acc_q     <= '0;
         num_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  err_q     <= 1'b0;
                  err_idx_q <= '0;
                  acc_q     <= '0;
                  num_q     <= num_insns;
                  if (num_insns == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_LOAD;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (push) begin
                  acc_q <= acc_q + CNT_WIDTH'(1);
                  if (pack_illegal) begin
                     err_q <= 1'b1;
                     if (!err_q) err_idx_q <= acc_q;
                  end
                  if (last_accept) state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Writes complete in the cycle they are accepted, so an empty
               // FIFO after this cycle means nothing is left outstanding.
               if (count_d == 2'd0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Two-entry word FIFO and the imem write pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         addr_q   <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= pack_word;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
            addr_q   <= addr_q + ADDR_WIDTH'(4);
         end
         if (start_take) addr_q <= base_addr;
         count_q <= count_d;
      end
   end

   assign imem_we    = (count_q != 2'd0);
   assign imem_addr  = addr_q;
   assign imem_wdata = mem_q[rd_ptr_q];
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign err_index  = err_idx_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Self-checking bench for insn_encoder: directed scenarios plus randomized
// programs compared against an arithmetic reference encoder.
module tb_insn_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] base_addr = '0;
   logic [9:0]  num_insns = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  fmt = '0;
   logic [6:0]  opcode = '0;
   logic [2:0]  funct3 = '0;
   logic [6:0]  funct7 = '0;
   logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
   logic [31:0] imm = '0;
   logic        imem_we;
   logic        imem_ready = 1'b1;
   logic [11:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        busy, done, err;
   logic [9:0]  err_index;

   int checks = 0;
   int failures = 0;

   // program under test
   logic [2:0]  p_fmt [64];
   logic [6:0]  p_op  [64];
   logic [2:0]  p_f3  [64];
   logic [6:0]  p_f7  [64];
   logic [4:0]  p_rd  [64], p_rs1 [64], p_rs2 [64];
   logic [31:0] p_imm [64];

   // expected results from the model
   logic [31:0] exp_data [64];
   logic        exp_err;
   int          exp_eidx;

   // observations from the driver
   logic [11:0] got_addr [$];
   logic [31:0] got_data [$];
   int          stall_viol;
   int          blocked_at;
   int          done_dt;
   bit          timed_out;

   insn_encoder #(.ADDR_WIDTH(12), .CNT_WIDTH(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .num_insns(num_insns), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
      .err_index(err_index)
   );

   always #5 clk = ~clk;

   // Reference encoder built from field shifts and integer range tests.
   function automatic logic [31:0] ref_word(input int f, input longint op, input longint f3,
                                            input longint f7, input longint d, input longint s1,
                                            input longint s2, input logic [31:0] im,
                                            output bit bad);
      longint v = longint'($signed(im));
      longint w = 0;
      longint common = (s1 << 15) | (f3 << 12) | op;
      bad = 0;
      case (f)
         0: w = (f7 << 25) | (s2 << 20) | common | (d << 7);
         1: begin bad = (v < -2048) || (v > 2047); w = ((v & 'hfff) << 20) | common | (d << 7); end
         2: begin bad = (v < -2048) || (v > 2047);
                  w = (((v >> 5) & 'h7f) << 25) | (s2 << 20) | common | ((v & 'h1f) << 7); end
         3: begin bad = (v < -4096) || (v > 4094) || ((v & 1) != 0);
                  w = (((v >> 12) & 1) << 31) | (((v >> 5) & 'h3f) << 25) | (s2 << 20) | common
                      | (((v >> 1) & 'hf) << 8) | (((v >> 11) & 1) << 7); end
         4: begin bad = (v & 'hfff) != 0; w = (v & 'hfffff000) | (d << 7) | op; end
         5: begin bad = (v < -1048576) || (v > 1048574) || ((v & 1) != 0);
                  w = (((v >> 20) & 1) << 31) | (((v >> 1) & 'h3ff) << 21) | (((v >> 11) & 1) << 20)
                      | (((v >> 12) & 'hff) << 12) | (d << 7) | op; end
         default: bad = 1;
      endcase
      if (bad) w = 'h13;
      return 32'(w);
   endfunction

   task automatic set_insn(input int i, input int f, input int op, input int f3, input int f7,
                           input int d, input int s1, input int s2, input logic [31:0] im);
      p_fmt[i] = 3'(f);  p_op[i] = 7'(op); p_f3[i] = 3'(f3); p_f7[i] = 7'(f7);
      p_rd[i] = 5'(d);   p_rs1[i] = 5'(s1); p_rs2[i] = 5'(s2); p_imm[i] = im;
   endtask

   task automatic model_prog(input int n);
      bit bad;
      exp_err = 1'b0;
      exp_eidx = 0;
      for (int i = 0; i < n; i++) begin
         exp_data[i] = ref_word(int'(p_fmt[i]), longint'(p_op[i]), longint'(p_f3[i]),
                                longint'(p_f7[i]), longint'(p_rd[i]), longint'(p_rs1[i]),
                                longint'(p_rs2[i]), p_imm[i], bad);
         if (bad && !exp_err) begin exp_err = 1'b1; exp_eidx = i; end
      end
   endtask

   // Runs one program; mode 0: ready always, 1: random ready, 2: ready low for stall_n cycles.
   task automatic run_prog(input logic [11:0] base, input int n, input int mode, input int stall_n);
      int idx = 0;
      int last_wr = -1;
      bit prev_stall = 0;
      logic [11:0] pa = '0;
      logic [31:0] pd = '0;
      got_addr.delete(); got_data.delete();
      stall_viol = 0; blocked_at = -1; done_dt = -1; timed_out = 1;
      @(negedge clk);
      start = 1'b1; base_addr = base; num_insns = 10'(n); imem_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (prev_stall && (imem_addr !== pa || imem_wdata !== pd)) stall_viol++;
         if (done) begin done_dt = cyc - last_wr; timed_out = 0; break; end
         case (mode)
            0: imem_ready = 1'b1;
            1: imem_ready = 1'($urandom_range(0, 1));
            default: imem_ready = (cyc < stall_n) ? 1'b0 : 1'b1;
         endcase
         in_valid = (idx < n);
         if (idx < n) begin
            fmt = p_fmt[idx]; opcode = p_op[idx]; funct3 = p_f3[idx]; funct7 = p_f7[idx];
            rd = p_rd[idx]; rs1 = p_rs1[idx]; rs2 = p_rs2[idx]; imm = p_imm[idx];
         end
         if (in_valid && !in_ready && blocked_at < 0) blocked_at = idx;
         if (in_valid && in_ready) idx++;
         if (imem_we && imem_ready) begin
            got_addr.push_back(imem_addr); got_data.push_back(imem_wdata); last_wr = cyc;
         end
         prev_stall = imem_we && !imem_ready; pa = imem_addr; pd = imem_wdata;
         @(negedge clk);
      end
      in_valid = 1'b0; imem_ready = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({imem_we, in_ready, busy, done, err, err_index, imem_addr, imem_wdata} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got we=%0b rdy=%0b busy=%0b done=%0b err=%0b idx=%0d addr=%h data=%h want all 0",
                  imem_we, in_ready, busy, done, err, err_index, imem_addr, imem_wdata);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_addi();
      set_insn(0, 1, 'h13, 0, 0, 1, 0, 0, 32'd5);
      run_prog(12'h100, 1, 0, 0);
      checks++;
      if (timed_out || got_addr.size() != 1) begin
         failures++; $display("FAIL addi_count got %0d writes (timeout=%0b) want 1", got_addr.size(), timed_out);
      end else begin
         $display("addi write addr=%h data=%h", got_addr[0], got_data[0]);
         checks++;
         if (got_addr[0] !== 12'h100 || got_data[0] !== 32'h0050_0093) begin
            failures++; $display("FAIL addi_word got %h/%h want 100/00500093", got_addr[0], got_data[0]);
         end
      end
      checks++;
      if (done_dt != 1) begin failures++; $display("FAIL addi_done_latency got %0d want 1", done_dt); end
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL addi_err got %0b want 0", err); end
   endtask

   task automatic test_sequence();
      logic [31:0] want [3];
      want[0] = 32'h0020_81B3; want[1] = 32'h0020_8463; want[2] = 32'h1234_52B7;
      set_insn(0, 0, 'h33, 0, 0, 3, 1, 2, 32'd0);
      set_insn(1, 3, 'h63, 0, 0, 0, 1, 2, 32'd8);
      set_insn(2, 4, 'h37, 0, 0, 5, 0, 0, 32'h1234_5000);
      run_prog(12'h200, 3, 0, 0);
      checks++;
      if (timed_out || got_addr.size() != 3) begin
         failures++; $display("FAIL seq_count got %0d writes (timeout=%0b) want 3", got_addr.size(), timed_out);
      end else begin
         for (int i = 0; i < 3; i++) begin
            $display("seq write %0d addr=%h data=%h", i, got_addr[i], got_data[i]);
            checks++;
            if (got_addr[i] !== 12'(12'h200 + 4 * i) || got_data[i] !== want[i]) begin
               failures++; $display("FAIL seq_word%0d got %h/%h want %h/%h", i, got_addr[i], got_data[i],
                                    12'(12'h200 + 4 * i), want[i]);
            end
         end
      end
   endtask

   task automatic test_imm_error();
      set_insn(0, 1, 'h13, 0, 0, 1, 0, 0, 32'd4096);
      set_insn(1, 0, 'h33, 0, 0, 3, 1, 2, 32'd0);
      set_insn(2, 1, 'h13, 0, 0, 2, 0, 0, -32'sd3000);
      model_prog(3);
      run_prog(12'h040, 3, 0, 0);
      checks++;
      if (timed_out || got_addr.size() != 3) begin
         failures++; $display("FAIL immerr_count got %0d writes want 3", got_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            $display("immerr write %0d addr=%h data=%h", i, got_addr[i], got_data[i]);
            checks++;
            if (got_data[i] !== exp_data[i]) begin
               failures++; $display("FAIL immerr_word%0d got %h want %h", i, got_data[i], exp_data[i]);
            end
         end
         checks++;
         if (got_data[0] !== 32'h13 || got_data[1] !== 32'h0020_81B3) begin
            failures++; $display("FAIL immerr_nop got %h/%h want 00000013/002081b3", got_data[0], got_data[1]);
         end
      end
      checks++;
      if (err !== 1'b1 || err_index !== 10'd0) begin
         failures++; $display("FAIL immerr_flag got err=%0b idx=%0d want 1/0", err, err_index);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) set_insn(i, 1, 'h13, 0, 0, i + 1, i, 0, 32'(i * 100 - 50));
      model_prog(3);
      run_prog(12'h300, 3, 2, 5);
      checks++;
      if (blocked_at != 2) begin failures++; $display("FAIL stall_inready got drop after %0d want 2", blocked_at); end
      checks++;
      if (stall_viol != 0) begin failures++; $display("FAIL stall_stable got %0d changes want 0", stall_viol); end
      checks++;
      if (timed_out || got_addr.size() != 3) begin
         failures++; $display("FAIL stall_count got %0d writes want 3", got_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            $display("stall write %0d addr=%h data=%h", i, got_addr[i], got_data[i]);
            checks++;
            if (got_addr[i] !== 12'(12'h300 + 4 * i) || got_data[i] !== exp_data[i]) begin
               failures++; $display("FAIL stall_word%0d got %h/%h want %h/%h", i, got_addr[i], got_data[i],
                                    12'(12'h300 + 4 * i), exp_data[i]);
            end
         end
      end
   endtask

   task automatic test_wrap();
      set_insn(0, 5, 'h6f, 0, 0, 1, 0, 0, 32'd2048);
      set_insn(1, 2, 'h23, 2, 0, 0, 3, 4, -32'sd4);
      model_prog(2);
      run_prog(12'hFFC, 2, 0, 0);
      checks++;
      if (timed_out || got_addr.size() != 2) begin
         failures++; $display("FAIL wrap_count got %0d writes want 2", got_addr.size());
      end else begin
         $display("wrap writes addr=%h,%h data=%h,%h", got_addr[0], got_addr[1], got_data[0], got_data[1]);
         checks++;
         if (got_addr[0] !== 12'hFFC || got_addr[1] !== 12'h000) begin
            failures++; $display("FAIL wrap_addr got %h,%h want ffc,000", got_addr[0], got_addr[1]);
         end
         checks++;
         if (got_data[0] !== exp_data[0] || got_data[1] !== exp_data[1]) begin
            failures++; $display("FAIL wrap_data got %h,%h want %h,%h", got_data[0], got_data[1],
                                 exp_data[0], exp_data[1]);
         end
      end
      run_prog(12'h080, 0, 0, 0);
      $display("zero-length program writes=%0d", got_addr.size());
      checks++;
      if (timed_out || got_addr.size() != 0) begin
         failures++; $display("FAIL zero_len got %0d writes (timeout=%0b) want 0 and done", got_addr.size(), timed_out);
      end
   endtask

   task automatic test_reset_mid();
      int idx = 0;
      set_insn(0, 6, 'h13, 0, 0, 1, 0, 0, 32'd0);
      set_insn(1, 1, 'h13, 0, 0, 2, 0, 0, 32'd7);
      @(negedge clk);
      start = 1'b1; base_addr = 12'h500; num_insns = 10'd2;
      @(negedge clk);
      start = 1'b0; imem_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid = (idx < 2);
         if (idx < 2) begin fmt = p_fmt[idx]; opcode = p_op[idx]; rd = p_rd[idx]; imm = p_imm[idx]; end
         if (in_valid && in_ready) idx++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (imem_we !== 1'b1 || err !== 1'b1 || busy !== 1'b1) begin
         failures++; $display("FAIL rstmid_pre got we=%0b err=%0b busy=%0b want 1/1/1", imem_we, err, busy);
      end
      rst_n = 1'b0;
      #1;
      $display("reset during drain: we=%0b addr=%h data=%h", imem_we, imem_addr, imem_wdata);
      checks++;
      if ({imem_we, in_ready, busy, done, err, err_index, imem_addr, imem_wdata} !== '0) begin
         failures++; $display("FAIL rstmid_outputs got we=%0b busy=%0b err=%0b addr=%h data=%h want all 0",
                              imem_we, busy, err, imem_addr, imem_wdata);
      end
      @(negedge clk); rst_n = 1'b1; imem_ready = 1'b1;
      set_insn(0, 1, 'h13, 0, 0, 1, 0, 0, 32'd5);
      run_prog(12'h100, 1, 0, 0);
      checks++;
      if (timed_out || got_addr.size() != 1 || got_addr[0] !== 12'h100 || got_data[0] !== 32'h0050_0093) begin
         failures++; $display("FAIL rstmid_restart got %0d writes want one 100/00500093", got_addr.size());
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         int n = $urandom_range(1, 12);
         logic [11:0] base = 12'($urandom_range(0, 1023) * 4);
         for (int i = 0; i < n; i++) begin
            logic [31:0] im;
            case ($urandom_range(0, 3))
               0: im = 32'($urandom_range(0, 10000)) - 32'd5000;
               1: im = $urandom;
               2: im = $urandom & 32'hFFFF_F000;
               default: im = (32'($urandom_range(0, 4194303)) - 32'd2097152) & ~32'd1;
            endcase
            set_insn(i, $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 7),
                     $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), im);
         end
         model_prog(n);
         run_prog(base, n, 1, 0);
         checks++;
         if (timed_out || got_addr.size() != n) begin
            failures++; $display("FAIL rand%0d_count got %0d writes want %0d", r, got_addr.size(), n);
         end else begin
            for (int i = 0; i < n; i++) begin
               $display("rand%0d write %0d addr=%h data=%h", r, i, got_addr[i], got_data[i]);
               checks++;
               if (got_addr[i] !== 12'(base + 12'(4 * i)) || got_data[i] !== exp_data[i]) begin
                  failures++; $display("FAIL rand%0d_word%0d got %h/%h want %h/%h", r, i, got_addr[i],
                                       got_data[i], 12'(base + 12'(4 * i)), exp_data[i]);
               end
            end
         end
         checks++;
         if (err !== exp_err || (exp_err && err_index !== 10'(exp_eidx))) begin
            failures++; $display("FAIL rand%0d_err got %0b/%0d want %0b/%0d", r, err, err_index, exp_err, exp_eidx);
         end
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_sequence();
      test_imm_error();
      test_stall();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
